// File: rtl/sdm_txp.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sdm_txp - first-order sigma-delta pulse-density transmitter.
//
// Signed samples are queued in a small FIFO. For each one the modulator sends
// a frame of 2^OSR_LOG bits on tx. The number of ones in the frame encodes the
// sample, so a receiver that counts ones per frame can recover it. Each bit
// adds the offset-binary sample u to a DW-bit accumulator and transmits the
// carry out.
//
// Ports
//   clk, rst       system clock; asynchronous active-high reset
//   clear          synchronous flush (FIFO, FSM, flags); wins over push
//   enable         allows frames to start; a running frame always completes
//   div            bit period = div+1 clk cycles, takes effect immediately
//   underrun_mode  0: send midscale on underrun, 1: repeat last sample
//   push, wdata    FIFO write port (signed DW-bit sample)
//   full, empty,
//   level          FIFO status
//   overflow       sticky: a push was dropped because the FIFO was full
//   underrun       sticky: a frame boundary was reached with the FIFO empty
//   busy           a frame is in progress (load cycle until back to IDLE)
//   tx             registered modulated bit stream
//   bit_stb        one-clk pulse when tx takes a new bit
//   frame_stb      bit_stb of bit 0 of each frame
// -----------------------------------------------------------------------------
module sdm_txp #(
   parameter int DW        = 4,
   parameter int OSR_LOG   = 4,
   parameter int DEPTH_LOG = 2,
   parameter int DIVW      = 8,
   parameter int CARRY     = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [DIVW-1:0]      div,
   input  logic                 underrun_mode,
   input  logic                 push,
   input  logic [DW-1:0]        wdata,
   output logic                 full,
   output logic                 empty,
   output logic [DEPTH_LOG:0]   level,
   output logic                 overflow,
   output logic                 underrun,
   output logic                 busy,
   output logic                 tx,
   output logic                 bit_stb,
   output logic                 frame_stb
);

   localparam int                   DEPTH    = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0]   LVL_FULL = (DEPTH_LOG+1)'(DEPTH);
   localparam logic [DEPTH_LOG:0]   LVL_ZERO = {(DEPTH_LOG+1){1'b0}};
   localparam logic [DEPTH_LOG:0]   LVL_ONE  = {{DEPTH_LOG{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG-1:0] PTR_ZERO = {DEPTH_LOG{1'b0}};
   localparam logic [DEPTH_LOG-1:0] PTR_ONE  = {{(DEPTH_LOG-1){1'b0}}, 1'b1};
   localparam logic [OSR_LOG-1:0]   IDX_ZERO = {OSR_LOG{1'b0}};
   localparam logic [OSR_LOG-1:0]   IDX_ONE  = {{(OSR_LOG-1){1'b0}}, 1'b1};
   localparam logic [OSR_LOG-1:0]   IDX_LAST = {OSR_LOG{1'b1}};
   localparam logic [DIVW-1:0]      CNT_ZERO = {DIVW{1'b0}};
   localparam logic [DIVW-1:0]      CNT_ONE  = {{(DIVW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0]        SMP_ZERO = {DW{1'b0}};

   // ST_STOP holds the last bit of a frame for its full period before IDLE
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [DIVW-1:0]      cnt_q, cnt_d;
   logic [OSR_LOG-1:0]   idx_q, idx_d;
   logic [DW-1:0]        acc_q, acc_d;
   logic [DW-1:0]        smp_q, smp_d;
   logic                 tx_q, tx_d;
   logic                 bit_stb_q, bit_stb_d;
   logic                 frame_stb_q, frame_stb_d;
   logic                 busy_q, busy_d;
   logic                 ovf_q, ovf_d;
   logic                 und_q, und_d;
   logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG:0]   lvl_q, lvl_d;
   logic [DW-1:0]        mem_q [DEPTH];

   logic                 full_s;
   logic                 empty_s;
   logic                 pop_s;
   logic                 push_ok_s;
   logic                 ovf_evt_s;
   logic                 tick_s;
   logic [DW-1:0]        u_s;
   logic [DW:0]          sum_s;
   logic [DW-1:0]        rdata_s;

   assign full_s    = (lvl_q == LVL_FULL);
   assign empty_s   = (lvl_q == LVL_ZERO);
   // a pop in the same cycle frees a slot, so a push on a full FIFO is kept
   assign push_ok_s = push & (~full_s | pop_s);
   assign ovf_evt_s = push & full_s & ~pop_s;
   assign rdata_s   = mem_q[rd_ptr_q];

   // offset-binary mapping: adding 2^(DW-1) is an MSB inversion
   assign u_s   = {~smp_q[DW-1], smp_q[DW-2:0]};
   assign sum_s = {1'b0, acc_q} + {1'b0, u_s};

   // divider compares against live div so a lowered value ticks at once
   assign tick_s = (state_q != ST_IDLE) && (cnt_q >= div);

   // FIFO pointer, occupancy and overflow next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      lvl_d    = lvl_q;
      ovf_d    = ovf_q | ovf_evt_s;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
         2'b10:   lvl_d = lvl_q + LVL_ONE;
         2'b01:   lvl_d = lvl_q - LVL_ONE;
         default: lvl_d = lvl_q;
      endcase
   end

   // FSM next-state, modulator datapath and strobes
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      smp_d       = smp_q;
      tx_d        = tx_q;
      bit_stb_d   = 1'b0;
      frame_stb_d = 1'b0;
      busy_d      = busy_q;
      und_d       = und_q;
      pop_s       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b0;
            busy_d = 1'b0;
            cnt_d  = CNT_ZERO;
            if (enable && !empty_s) begin
               pop_s   = 1'b1;
               smp_d   = rdata_s;
               acc_d   = SMP_ZERO;
               idx_d   = IDX_ZERO;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            busy_d = 1'b1;
            if (tick_s) begin
               cnt_d       = CNT_ZERO;
               tx_d        = sum_s[DW];
               acc_d       = sum_s[DW-1:0];
               bit_stb_d   = 1'b1;
               frame_stb_d = (idx_q == IDX_ZERO);
               idx_d       = idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) begin
                  if (!enable) begin
                     state_d = ST_STOP;
                  end else if (!empty_s) begin
                     pop_s = 1'b1;
                     smp_d = rdata_s;
                  end else begin
                     und_d = 1'b1;
                     if (!underrun_mode) begin
                        smp_d = SMP_ZERO;
                     end else begin
                        smp_d = smp_q;
                     end
                  end
                  // exact-count mode restarts every frame from a clean accumulator
                  if (CARRY == 0) begin
                     acc_d = SMP_ZERO;
                  end else begin
                     acc_d = sum_s[DW-1:0];
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_STOP: begin
            busy_d = 1'b1;
            if (tick_s) begin
               cnt_d   = CNT_ZERO;
               tx_d    = 1'b0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            tx_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
         end
      endcase
   end

   // state registers; clear restores the reset image and overrides push
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= CNT_ZERO;
         idx_q       <= IDX_ZERO;
         acc_q       <= SMP_ZERO;
         smp_q       <= SMP_ZERO;
         tx_q        <= 1'b0;
         bit_stb_q   <= 1'b0;
         frame_stb_q <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
         und_q       <= 1'b0;
         wr_ptr_q    <= PTR_ZERO;
         rd_ptr_q    <= PTR_ZERO;
         lvl_q       <= LVL_ZERO;
      end else if (clear) begin
         state_q     <= ST_IDLE;
         cnt_q       <= CNT_ZERO;
         idx_q       <= IDX_ZERO;
         acc_q       <= SMP_ZERO;
         smp_q       <= SMP_ZERO;
         tx_q        <= 1'b0;
         bit_stb_q   <= 1'b0;
         frame_stb_q <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
         und_q       <= 1'b0;
         wr_ptr_q    <= PTR_ZERO;
         rd_ptr_q    <= PTR_ZERO;
         lvl_q       <= LVL_ZERO;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         smp_q       <= smp_d;
         tx_q        <= tx_d;
         bit_stb_q   <= bit_stb_d;
         frame_stb_q <= frame_stb_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
         und_q       <= und_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         lvl_q       <= lvl_d;
      end
   end

   // FIFO storage; contents are don't-care while the level is zero
   always_ff @(posedge clk) begin
      if (push_ok_s && !clear && !rst) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign full      = full_s;
   assign empty     = empty_s;
   assign level     = lvl_q;
   assign overflow  = ovf_q;
   assign underrun  = und_q;
   assign busy      = busy_q;
   assign tx        = tx_q;
   assign bit_stb   = bit_stb_q;
   assign frame_stb = frame_stb_q;

endmodule

// File: tb/tb_sdm_txp.sv
`timescale 1ns/1ps
// Directed bench for sdm_txp. Instance a uses DW=4/OSR_LOG=4, instance b uses
// DW=4/OSR_LOG=5; both share every input.
module tb_sdm_txp;

   logic       clk = 1'b0;
   logic       rst, clear, enable, underrun_mode, push;
   logic [7:0] div;
   logic [3:0] wdata;

   logic       a_full, a_empty, a_overflow, a_underrun, a_busy, a_tx, a_bit_stb, a_frame_stb;
   logic [2:0] a_level;
   logic       b_full, b_empty, b_overflow, b_underrun, b_busy, b_tx, b_bit_stb, b_frame_stb;
   logic [2:0] b_level;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sdm_txp #(.DW(4), .OSR_LOG(4), .DEPTH_LOG(2), .DIVW(8), .CARRY(0)) u_dut_a (
      .clk(clk), .rst(rst), .clear(clear), .enable(enable), .div(div),
      .underrun_mode(underrun_mode), .push(push), .wdata(wdata),
      .full(a_full), .empty(a_empty), .level(a_level), .overflow(a_overflow),
      .underrun(a_underrun), .busy(a_busy), .tx(a_tx), .bit_stb(a_bit_stb),
      .frame_stb(a_frame_stb)
   );

   sdm_txp #(.DW(4), .OSR_LOG(5), .DEPTH_LOG(2), .DIVW(8), .CARRY(0)) u_dut_b (
      .clk(clk), .rst(rst), .clear(clear), .enable(enable), .div(div),
      .underrun_mode(underrun_mode), .push(push), .wdata(wdata),
      .full(b_full), .empty(b_empty), .level(b_level), .overflow(b_overflow),
      .underrun(b_underrun), .busy(b_busy), .tx(b_tx), .bit_stb(b_bit_stb),
      .frame_stb(b_frame_stb)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // waits (bounded) for the next bit strobe of instance sel
   task automatic wait_bit(input int sel, output int cyc, output logic b, output logic fs);
      logic stb;
      cyc = 0;
      stb = 1'b0;
      while (!stb && cyc < 64) begin
         step();
         cyc++;
         stb = (sel != 0) ? b_bit_stb : a_bit_stb;
      end
      check("bit_stb_seen", {31'd0, stb}, 32'd1);
      b  = (sel != 0) ? b_tx : a_tx;
      fs = (sel != 0) ? b_frame_stb : a_frame_stb;
   endtask

   task automatic collect(input int sel, input int n, input int per,
                          output logic [31:0] bits, output int fs_cnt,
                          output int first_cyc, output int bad_per);
      int   cyc;
      logic b, fs;
      bits      = 32'd0;
      fs_cnt    = 0;
      first_cyc = 0;
      bad_per   = 0;
      for (int i = 0; i < n; i++) begin
         wait_bit(sel, cyc, b, fs);
         bits[i] = b;
         fs_cnt += int'(fs);
         if (i == 0) first_cyc = cyc;
         else if (cyc != per) bad_per++;
      end
   endtask

   task automatic push1(input logic [3:0] v);
      push  = 1'b1;
      wdata = v;
      step();
      push  = 1'b0;
   endtask

   task automatic do_clear();
      enable = 1'b0;
      push   = 1'b0;
      clear  = 1'b1;
      step();
      clear  = 1'b0;
   endtask

   task automatic quiet_window(input string tag);
      int strobes;
      strobes = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         strobes += int'(a_bit_stb) + int'(a_frame_stb);
      end
      check(tag, strobes, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bits;
      int          fs_cnt, first_cyc, bad_per, cyc;
      logic        b, fs;
      int          exp_ones [5];

      rst = 1'b1; clear = 1'b0; enable = 1'b0; underrun_mode = 1'b0;
      push = 1'b0; div = 8'd3; wdata = 4'd0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // reset state
      check("rst_tx", a_tx, 1'b0);
      check("rst_bit_stb", a_bit_stb, 1'b0);
      check("rst_frame_stb", a_frame_stb, 1'b0);
      check("rst_busy", a_busy, 1'b0);
      check("rst_overflow", a_overflow, 1'b0);
      check("rst_underrun", a_underrun, 1'b0);
      check("rst_level", a_level, 3'd0);
      check("rst_empty", a_empty, 1'b1);
      check("rst_full", a_full, 1'b0);

      // 1: most negative sample -> all zeros, one frame strobe, underrun
      push1(4'b1000);
      enable = 1'b1;
      collect(0, 15, 4, bits, fs_cnt, first_cyc, bad_per);
      check("t1_first_latency", first_cyc, 32'd5);
      check("t1_underrun_mid", a_underrun, 1'b0);
      check("t1_busy", a_busy, 1'b1);
      begin
         logic [31:0] last;
         int f2, c2, p2;
         collect(0, 1, 4, last, f2, c2, p2);
         bits[15] = last[0];
         fs_cnt  += f2;
         check("t1_last_period", c2, 32'd4);
      end
      check("t1_bits", bits[15:0], 16'h0000);
      check("t1_period", bad_per, 32'd0);
      check("t1_frame_stb", fs_cnt, 32'd1);
      check("t1_underrun", a_underrun, 1'b1);

      // 2: 7 then 0 -> 15 ones then alternating, gapless
      do_clear();
      push1(4'd7);
      push1(4'd0);
      enable = 1'b1;
      collect(0, 16, 4, bits, fs_cnt, first_cyc, bad_per);
      check("t2_f1_bits", bits[15:0], 16'hFFFE);
      check("t2_f1_period", bad_per, 32'd0);
      check("t2_f1_fstb", fs_cnt, 32'd1);
      check("t2_f1_underrun", a_underrun, 1'b0);
      collect(0, 16, 4, bits, fs_cnt, first_cyc, bad_per);
      check("t2_gapless", first_cyc, 32'd4);
      check("t2_f2_bits", bits[15:0], 16'hAAAA);
      check("t2_f2_ones", $countones(bits[15:0]), 32'd8);
      check("t2_f2_fstb", fs_cnt, 32'd1);
      check("t2_f2_underrun", a_underrun, 1'b1);

      // 3: repeat-last underrun mode, then midscale mode
      do_clear();
      underrun_mode = 1'b1;
      push1(4'd5);
      enable = 1'b1;
      collect(0, 16, 4, bits, fs_cnt, first_cyc, bad_per);
      check("t3r_f1_ones", $countones(bits[15:0]), 32'd13);
      check("t3r_underrun", a_underrun, 1'b1);
      collect(0, 16, 4, bits, fs_cnt, first_cyc, bad_per);
      check("t3r_f2_ones", $countones(bits[15:0]), 32'd13);
      check("t3r_gapless", first_cyc, 32'd4);
      do_clear();
      underrun_mode = 1'b0;
      push1(4'd5);
      enable = 1'b1;
      collect(0, 16, 4, bits, fs_cnt, first_cyc, bad_per);
      check("t3m_f1_ones", $countones(bits[15:0]), 32'd13);
      collect(0, 16, 4, bits, fs_cnt, first_cyc, bad_per);
      check("t3m_f2_bits", bits[15:0], 16'hAAAA);

      // 4: FIFO fill, overflow, push accepted alongside a pop
      do_clear();
      push1(4'd1);
      push1(4'd2);
      push1(4'd3);
      push1(4'd4);
      check("t4_full", a_full, 1'b1);
      check("t4_level4", a_level, 3'd4);
      check("t4_no_ovf", a_overflow, 1'b0);
      push1(4'd5);
      check("t4_ovf", a_overflow, 1'b1);
      check("t4_level_after_drop", a_level, 3'd4);
      push = 1'b1; wdata = 4'd6; enable = 1'b1;
      step();
      push = 1'b0;
      check("t4_level_push_pop", a_level, 3'd4);
      check("t4_busy", a_busy, 1'b1);
      exp_ones = '{9, 10, 11, 12, 14};
      for (int f = 0; f < 5; f++) begin
         collect(0, 16, 4, bits, fs_cnt, first_cyc, bad_per);
         check($sformatf("t4_frame%0d_ones", f), $countones(bits[15:0]), exp_ones[f]);
      end
      check("t4_underrun", a_underrun, 1'b1);

      // 5a: clear mid-frame (instance a is sending midscale now)
      for (int k = 0; k < 4 && a_tx !== 1'b1; k++) wait_bit(0, cyc, b, fs);
      check("t5_tx_high_before", a_tx, 1'b1);
      push1(4'd7);
      check("t5_ovf_before", a_overflow, 1'b1);
      clear = 1'b1; push = 1'b1; wdata = 4'd7;
      step();
      clear = 1'b0; push = 1'b0;
      check("t5c_tx", a_tx, 1'b0);
      check("t5c_empty", a_empty, 1'b1);
      check("t5c_level", a_level, 3'd0);
      check("t5c_overflow", a_overflow, 1'b0);
      check("t5c_underrun", a_underrun, 1'b0);
      check("t5c_busy", a_busy, 1'b0);
      quiet_window("t5c_no_strobes");

      // 5b: asynchronous reset mid-frame
      push1(4'd7);
      push1(4'd7);
      for (int k = 0; k < 3; k++) wait_bit(0, cyc, b, fs);
      check("t5r_tx_high_before", a_tx, 1'b1);
      rst = 1'b1;
      #1;
      check("t5r_tx", a_tx, 1'b0);
      check("t5r_empty", a_empty, 1'b1);
      check("t5r_level", a_level, 3'd0);
      check("t5r_busy", a_busy, 1'b0);
      step();
      rst = 1'b0;
      quiet_window("t5r_no_strobes");

      // 6: 32-bit frames, and divider changes mid-frame
      do_clear();
      div = 8'd3;
      push1(4'd3);
      enable = 1'b1;
      collect(1, 32, 4, bits, fs_cnt, first_cyc, bad_per);
      check("t6_ones", $countones(bits), 32'd22);
      check("t6_period", bad_per, 32'd0);
      check("t6_fstb", fs_cnt, 32'd1);
      wait_bit(1, cyc, b, fs);
      div = 8'd1;
      wait_bit(1, cyc, b, fs);
      check("t6_div1_p1", cyc, 32'd2);
      wait_bit(1, cyc, b, fs);
      check("t6_div1_p2", cyc, 32'd2);
      div = 8'd3;
      wait_bit(1, cyc, b, fs);
      check("t6_div3_p", cyc, 32'd4);
      step();
      step();
      div = 8'd1;
      wait_bit(1, cyc, b, fs);
      check("t6_below_cnt", cyc, 32'd1);
      wait_bit(1, cyc, b, fs);
      check("t6_after_below", cyc, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sdm_txp.md
Name: sdm_txp

Overview:
Parametrised sigma-delta pulse-density transmitter. It replaces the fixed 4-bit/16-entry weight-table transmitter with a first-order accumulator modulator. It adds configurable sample width, oversampling ratio, bit-rate divider, a sample FIFO, underrun handling and status flags. It sits between a sample producer on the system clock and a single-wire tx pin, and is decodable by a ones-counting receiver.

Parameters:
DW, 4, signed sample width in bits (2..12).
OSR_LOG, 4, log2 of bits per frame; must be >= DW.
DEPTH_LOG, 2, log2 of FIFO depth (depth 4).
DIVW, 8, width of the bit-period divider.
CARRY, 0, 0: accumulator cleared each frame (exact count); 1: residue carried across frames.

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  asynchronous active-high reset.
clear  in  1  synchronous flush: FIFO emptied, FSM to IDLE, flags cleared.
enable  in  1  allow frames to start.
div  in  DIVW  bit period = div+1 clk cycles.
underrun_mode  in  1  0: send midscale (value 0) on underrun; 1: repeat last sample.
push  in  1  write wdata into FIFO.
wdata  in  DW  signed sample.
full  out  1  FIFO full.
empty  out  1  FIFO empty.
level  out  DEPTH_LOG+1  FIFO occupancy.
overflow  out  1  sticky: push while full without same-cycle pop.
underrun  out  1  sticky: frame boundary reached with FIFO empty while enable=1.
busy  out  1  FSM in RUN.
tx  out  1  modulated bit stream, registered.
bit_stb  out  1  one-clk pulse in the cycle tx takes a new bit.
frame_stb  out  1  one-clk pulse coincident with bit_stb of bit 0 of each frame.

Behaviour:
- Reset/clear: tx=0, bit_stb=0, frame_stb=0, busy=0, overflow=0, underrun=0, level=0, empty=1, full=0. Accumulator, divider count, bit index and sample register are all 0. clear has priority over push in the same cycle.
- FIFO: depth 2^DEPTH_LOG, first-in first-out. A push while full is dropped and sets overflow, unless a pop occurs in the same cycle, in which case it is accepted. level updates the cycle after push/pop.
- Mapping: u = wdata + 2^(DW-1), unsigned 0..2^DW-1.
- Modulation: each bit, {c, acc} = acc + u (DW+1 bits); tx <= c; acc <= low DW bits. With acc=0 at frame start, the ones per frame are exactly u << (OSR_LOG-DW). Examples: -2^(DW-1) gives all zeros; 0 gives alternating 0,1 starting with 0.
- Divider: cnt increments each clk in RUN. Tick when cnt >= div, then cnt <= 0. A div change takes effect immediately; lowering div below cnt ticks on the next cycle.
- FSM IDLE: tx held 0. On enable=1 and empty=0: pop the FIFO, load the sample register, and clear acc, cnt and bit index. Go to RUN. The first bit_stb comes div+1 cycles later.
- FSM RUN, each tick: tx updated, bit_stb=1, bit index increments; frame_stb=1 when the index was 0.
- Last bit of a frame (index 2^OSR_LOG-1), at its tick:
  - enable=0: go to IDLE after the bit; tx stays at the last bit value for div+1 cycles, then 0.
  - FIFO non-empty: pop, load the sample register, and clear acc if CARRY=0.
  - FIFO empty: set underrun and load the sample register with 0 (underrun_mode=0) or keep it (underrun_mode=1). Stay in RUN.
- Frames are gapless: the first bit of the next frame follows the last bit by exactly div+1 cycles.
- enable deasserted mid-frame: the current frame completes, then IDLE.
- Reset or clear mid-frame: tx=0 the next clk edge (asynchronously for rst); the partial frame is discarded.
- busy=1 from the load cycle until the return to IDLE.

Test Plan:
1. DW=4, OSR_LOG=4, div=3; push -8, enable -> 16 bits of 0; bit_stb every 4 clks; one frame_stb; underrun=1 after the frame.
2. Push 7, then 0, enable -> frame 1 has 15 ones; frame 2 is 0,1,0,1,... with 8 ones; no gap between frames.
3. Push 5 once, underrun_mode=1 -> 13 ones per frame repeated; underrun=1 at the first boundary. With underrun_mode=0 -> midscale pattern after frame 1.
4. Five pushes with enable=0, depth 4 -> full=1, level=4, overflow=1. A push coincident with a pop when full is accepted and level stays 4.
5. Mid-frame, assert clear, and separately rst -> tx=0 and empty=1 next cycle; flags cleared; no frame_stb until a new push and enable.
6. DW=4, OSR_LOG=5, CARRY=0; push 3 -> 22 ones in 32 bits. Change div from 3 to 1 mid-frame -> bit_stb period becomes 2 from the next tick.
